// File: rtl/multicycle_ctrl.sv
// Purpose : multicycle RV32 subset control FSM (R, IALU, LOAD, STORE, JALR) with a retire counter.
// Latency : 4 cycles per R/IALU/JALR, 5 per LOAD, 4 per STORE, plus memory wait cycles in FETCH and MEM.
// Backpres: mem_req/mem_we/addr_sel hold steady until mem_ready; run gates only the start of a fetch.
// Ports   : clk, rst_n (async, active-low); run, opcode (IR[6:0]), mem_ready in;
//           mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b, alu_op,
//           reg_write, mem_to_reg, illegal, state, instret out.
module multicycle_ctrl #(
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [31:0]      instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } stateT;

  localparam logic [OPC_W-1:0] OPC_R     = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OPC_IALU  = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OPC_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(7'b0100011);

  stateT stateReg;
  stateT stateNext;
  logic  fetchPend;   // a fetch request is outstanding, so it must survive run dropping
  logic  retire;
  logic  isR, isLoad, isIalu, isJalr, isStore, isLegal;

  assign isR     = (opcode == OPC_R);
  assign isLoad  = (opcode == OPC_LOAD);
  assign isIalu  = (opcode == OPC_IALU);
  assign isJalr  = (opcode == OPC_JALR);
  assign isStore = (opcode == OPC_STORE);
  assign isLegal = isR | isLoad | isIalu | isJalr | isStore;

  assign state = stateReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= FETCH;
      fetchPend <= 1'b0;
      instret   <= 32'd0;
    end else begin
      stateReg  <= stateNext;
      fetchPend <= (stateReg == FETCH) && mem_req && !mem_ready;
      if (retire) instret <= instret + 32'd1;   // wraps naturally at 2^32
    end
  end

  always_comb begin
    stateNext  = stateReg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;
    // Outputs are gated by rst_n so that reset clears them without waiting for a clock.
    if (rst_n) begin
      case (stateReg)
        FETCH: begin
          mem_req = run | fetchPend;
          if (mem_req && mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            stateNext = DECODE;
          end
        end
        DECODE: stateNext = isLegal ? EXEC : TRAP;
        EXEC: begin
          if (isR) begin
            alu_op    = 2'b10;
            stateNext = WB;
          end else if (isIalu) begin
            alu_src_b = 1'b1;
            alu_op    = 2'b11;
            stateNext = WB;
          end else if (isLoad || isStore) begin
            alu_src_b = 1'b1;
            stateNext = MEM;
          end else if (isJalr) begin
            alu_src_b = 1'b1;
            stateNext = WB;
          end else begin
            stateNext = FETCH;
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = isStore;
          if (mem_ready) begin
            stateNext = isStore ? FETCH : WB;
            retire    = isStore;
          end
        end
        WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          stateNext = FETCH;
          if (isLoad) begin
            mem_to_reg = 2'b01;
          end else if (isJalr) begin
            // rd takes the current PC (already PC+4) while PC moves to ALUOut.
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 1'b1;
          end
        end
        TRAP: illegal = 1'b1;
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : scoreboard bench for multicycle_ctrl; per-cycle expected vectors queued by stimulus.
// Latency : monitor compares each queued vector on the falling edge of the same cycle.
// Backpres: none; stimulus drives one vector per cycle, monitor drains the queue.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  typedef struct packed {
    logic [2:0]  st;
    logic [12:0] outs;
    logic [31:0] ir;
  } expT;

  expT sbq[$];
  int  checks = 0;
  int  errors = 0;

  // outs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b, alu_op[1:0], reg_write, mem_to_reg[1:0], illegal}
  localparam logic [12:0] IDLE  = 13'b0_0_0_0_0_0_0_00_0_00_0;
  localparam logic [12:0] F_REQ = 13'b1_0_0_0_0_0_0_00_0_00_0;
  localparam logic [12:0] F_ACC = 13'b1_0_0_1_1_0_0_00_0_00_0;
  localparam logic [12:0] EX_R  = 13'b0_0_0_0_0_0_0_10_0_00_0;
  localparam logic [12:0] EX_I  = 13'b0_0_0_0_0_0_1_11_0_00_0;
  localparam logic [12:0] EX_A  = 13'b0_0_0_0_0_0_1_00_0_00_0;
  localparam logic [12:0] M_LD  = 13'b1_0_1_0_0_0_0_00_0_00_0;
  localparam logic [12:0] M_ST  = 13'b1_1_1_0_0_0_0_00_0_00_0;
  localparam logic [12:0] WB_R  = 13'b0_0_0_0_0_0_0_00_1_00_0;
  localparam logic [12:0] WB_LD = 13'b0_0_0_0_0_0_0_00_1_01_0;
  localparam logic [12:0] WB_J  = 13'b0_0_0_0_1_1_0_00_1_10_0;
  localparam logic [12:0] TRAPO = 13'b0_0_0_0_0_0_0_00_0_00_1;

  localparam logic [6:0] OR  = 7'b0110011;
  localparam logic [6:0] OLD = 7'b0000011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] OJ  = 7'b1100111;
  localparam logic [6:0] OST = 7'b0100011;
  localparam logic [6:0] OIL = 7'b1111111;

  multicycle_ctrl #(.OPC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state(state), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops one expected vector per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      expT e;
      expT a;
      e = sbq.pop_front();
      a = {state, {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_b,
                   alu_op, reg_write, mem_to_reg, illegal}, instret};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec chk%0d t=%0t: got state=%0d outs=%b instret=%0d, want state=%0d outs=%b instret=%0d",
                 checks, $time, a.st, a.outs, a.ir, e.st, e.outs, e.ir);
      end
    end
  end

  task automatic step(input logic rs, input logic r, input logic [6:0] op, input logic rdy,
                      input logic [2:0] st, input logic [12:0] o, input logic [31:0] ir,
                      input int n);
    expT e;
    rst_n     = rs;
    run       = r;
    opcode    = op;
    mem_ready = rdy;
    e = {st, o, ir};
    for (int i = 0; i < n; i++) begin
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; opcode = OR; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset holds everything low even with run=1 in FETCH.
    step(0, 1, OR, 1, 0, IDLE, 0, 1);
    // R-type, zero-wait memory: 0,1,2,4,0.
    step(1, 1, OR, 1, 0, F_ACC, 0, 1);
    step(1, 1, OR, 1, 1, IDLE,  0, 1);
    step(1, 1, OR, 1, 2, EX_R,  0, 1);
    step(1, 1, OR, 1, 4, WB_R,  0, 1);
    step(1, 0, OR, 1, 0, IDLE,  1, 2);   // run=0: mem_ready ignored, stays FETCH
    // LOAD, 3 wait cycles in FETCH and MEM; run drops after the fetch is issued.
    step(1, 1, OLD, 0, 0, F_REQ, 1, 1);
    step(1, 0, OLD, 0, 0, F_REQ, 1, 2);
    step(1, 0, OLD, 1, 0, F_ACC, 1, 1);
    step(1, 0, OLD, 1, 1, IDLE,  1, 1);
    step(1, 0, OLD, 1, 2, EX_A,  1, 1);
    step(1, 0, OLD, 0, 3, M_LD,  1, 3);
    step(1, 0, OLD, 1, 3, M_LD,  1, 1);
    step(1, 0, OLD, 0, 4, WB_LD, 1, 1);
    step(1, 0, OLD, 0, 0, IDLE,  2, 1);
    // STORE: MEM writes, back to FETCH without WB; run drop does not abort MEM.
    step(1, 1, OST, 1, 0, F_ACC, 2, 1);
    step(1, 1, OST, 1, 1, IDLE,  2, 1);
    step(1, 1, OST, 0, 2, EX_A,  2, 1);
    step(1, 1, OST, 0, 3, M_ST,  2, 1);
    step(1, 0, OST, 1, 3, M_ST,  2, 1);
    step(1, 0, OST, 0, 0, IDLE,  3, 1);
    // JALR: WB writes rd from PC and redirects PC in the same cycle.
    step(1, 1, OJ, 1, 0, F_ACC, 3, 1);
    step(1, 1, OJ, 1, 1, IDLE,  3, 1);
    step(1, 1, OJ, 1, 2, EX_A,  3, 1);
    step(1, 1, OJ, 1, 4, WB_J,  3, 1);
    step(1, 0, OJ, 1, 0, IDLE,  4, 1);
    // IALU.
    step(1, 1, OI, 1, 0, F_ACC, 4, 1);
    step(1, 1, OI, 1, 1, IDLE,  4, 1);
    step(1, 1, OI, 1, 2, EX_I,  4, 1);
    step(1, 1, OI, 1, 4, WB_R,  4, 1);
    step(1, 0, OI, 1, 0, IDLE,  5, 1);
    // LOAD interrupted by reset while waiting in MEM.
    step(1, 1, OLD, 1, 0, F_ACC, 5, 1);
    step(1, 1, OLD, 1, 1, IDLE,  5, 1);
    step(1, 1, OLD, 0, 2, EX_A,  5, 1);
    step(1, 1, OLD, 0, 3, M_LD,  5, 2);
    step(0, 1, OLD, 0, 0, IDLE,  0, 1);  // checked before any clock edge
    step(1, 0, OLD, 1, 0, IDLE,  0, 3);
    // Illegal opcode: DECODE then TRAP, sticky through 20 cycles of run=1.
    step(1, 1, OIL, 1, 0, F_ACC, 0, 1);
    step(1, 1, OIL, 1, 1, IDLE,  0, 1);
    step(1, 1, OIL, 1, 5, TRAPO, 0, 20);
    step(0, 1, OIL, 1, 0, IDLE,  0, 1);
    step(1, 0, OIL, 1, 0, IDLE,  0, 2);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d vectors unchecked, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

endmodule
